// File: rtl/conv_pkg.sv
// Shared pixel type, legal parameter limits and memory target selection for the conv line-buffer blocks.
package conv_pkg;

    typedef logic [7:0] pixel_t;

    localparam int K_MIN     = 3;
    localparam int K_MAX     = 7;
    localparam int W_MAX_MIN = 4;

    typedef enum logic [0:0] {
        TGT_FPGA = 1'b0,
        TGT_ASIC = 1'b1
    } target_e;

    // Line stores map onto this target's RAM macro; conv_lb_mem is the swap point.
    localparam target_e TARGET = TGT_FPGA;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/conv_cntrl_lb_ring_if.sv
// Pixel-in / column-out handshake bundle for conv_cntrl_lb_ring; master is the producer/consumer side.
interface conv_cntrl_lb_ring_if
    import conv_pkg::*;
#(
    parameter int K = 5
);
    logic               in_vld_i;
    logic               in_rdy_o;
    pixel_t             in_dat_i;
    logic               in_sof_i;
    logic               in_eol_i;
    logic               out_vld_o;
    logic               out_rdy_i;
    pixel_t [K-1:0]     out_col_o;
    logic               out_sof_o;
    logic               out_eol_o;
    logic               primed_o;
    logic               err_len_o;

    modport master (
        output in_vld_i, in_dat_i, in_sof_i, in_eol_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, out_col_o, out_sof_o, out_eol_o, primed_o, err_len_o
    );

    modport slave (
        input  in_vld_i, in_dat_i, in_sof_i, in_eol_i, out_rdy_i,
        output in_rdy_o, out_vld_o, out_col_o, out_sof_o, out_eol_o, primed_o, err_len_o
    );
endinterface

// File: rtl/conv_lb_mem.sv
// One line store: 1R1W, W_MAX x pixel_t, registered read returning old data on a same-address write.
// Behavioural model shared by all targets; replace the body with the target macro when conv_pkg::TARGET demands it.
module conv_lb_mem
    import conv_pkg::*;
#(
    parameter int W_MAX = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(W_MAX)-1:0] waddr,
    input  pixel_t                   wdat,
    input  logic                     re,
    input  logic [$clog2(W_MAX)-1:0] raddr,
    output pixel_t                   rdat
);
    pixel_t mem [W_MAX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdat;
        end
        if (re) begin
            rdat <= mem[raddr];
        end
    end
endmodule

// File: rtl/conv_cntrl_lb_ring.sv
// K-row line-buffer ring: turns a raster pixel stream into vertical K-pixel columns with zero padding above a frame.
// Latency 1 cycle (registered column); in_rdy drops only while a held column is refused downstream.
module conv_cntrl_lb_ring
    import conv_pkg::*;
#(
    parameter int K     = 5,
    parameter int W_MAX = 1024
) (
    input  logic                 clk,
    input  logic                 arst_n,
    conv_cntrl_lb_ring_if.slave  bus
);
    localparam int N     = K - 1;
    localparam int AW    = $clog2(W_MAX);
    localparam int CNT_W = 3;

    if ((K % 2) == 0 || K < K_MIN || K > K_MAX) begin : g_bad_k
        $error("conv_cntrl_lb_ring: K must be odd and within 3..7");
    end
    if (!is_pow2(W_MAX) || W_MAX < W_MAX_MIN) begin : g_bad_w
        $error("conv_cntrl_lb_ring: W_MAX must be a power of two and at least 4");
    end

    logic [AW-1:0]    col_q;
    logic [N-1:0]     sel_q;
    logic [N-1:0]     fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    logic             out_vld_q;

    pixel_t           cur_q;
    logic             sof_q;
    logic             eol_q;
    logic [N-1:0]     rd_sel_q;
    logic [N-1:0]     rd_fill_q;
    pixel_t           rd_dat [N];

    logic             xfer;
    logic [AW-1:0]    col_eff;
    logic [N-1:0]     sel_eff;
    logic [N-1:0]     fill_eff;
    logic [CNT_W-1:0] cnt_eff;
    logic             at_end;
    logic             eol_eff;
    logic             overflow;

    assign bus.in_rdy_o = !out_vld_q || bus.out_rdy_i;
    assign xfer         = bus.in_vld_i && bus.in_rdy_o;

    // SOF restarts the frame before this pixel's read, so the pixel sees an empty ring.
    assign col_eff  = bus.in_sof_i ? '0      : col_q;
    assign sel_eff  = bus.in_sof_i ? N'(1)   : sel_q;
    assign fill_eff = bus.in_sof_i ? '0      : fill_q;
    assign cnt_eff  = bus.in_sof_i ? '0      : cnt_q;
    assign at_end   = (col_eff == {AW{1'b1}});
    assign eol_eff  = bus.in_eol_i || at_end;
    assign overflow = at_end && !bus.in_eol_i;

    for (genvar g = 0; g < N; g++) begin : g_store
        conv_lb_mem #(
            .W_MAX (W_MAX)
        ) u_mem (
            .clk   (clk),
            .we    (xfer && sel_eff[g]),
            .waddr (col_eff),
            .wdat  (bus.in_dat_i),
            .re    (xfer),
            .raddr (col_eff),
            .rdat  (rd_dat[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            out_vld_q <= 1'b0;
            col_q     <= '0;
            sel_q     <= N'(1);
            fill_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            if (xfer) begin
                out_vld_q <= 1'b1;
            end else if (bus.out_rdy_i) begin
                out_vld_q <= 1'b0;
            end

            if (xfer) begin
                err_q <= (bus.in_sof_i ? 1'b0 : err_q) | overflow;
                if (eol_eff) begin
                    col_q  <= '0;
                    sel_q  <= {sel_eff[N-2:0], sel_eff[N-1]};
                    fill_q <= fill_eff | sel_eff;
                    cnt_q  <= (cnt_eff == CNT_W'(N)) ? cnt_eff : cnt_eff + CNT_W'(1);
                end else begin
                    col_q  <= col_eff + AW'(1);
                    sel_q  <= sel_eff;
                    fill_q <= fill_eff;
                    cnt_q  <= cnt_eff;
                end
            end
        end
    end

    // Snapshot of ring state taken with the read, used to rotate and pad the RAM outputs.
    always_ff @(posedge clk) begin
        if (xfer) begin
            cur_q     <= bus.in_dat_i;
            sof_q     <= bus.in_sof_i;
            eol_q     <= eol_eff;
            rd_sel_q  <= sel_eff;
            rd_fill_q <= fill_eff;
        end
    end

    // Row j comes from the store j positions behind the write store: store s when the writer was (s+j) mod N.
    always_comb begin
        bus.out_col_o    = '0;
        bus.out_col_o[0] = cur_q;
        for (int j = 1; j < K; j++) begin
            for (int s = 0; s < N; s++) begin
                if (rd_sel_q[(s + j) % N] && rd_fill_q[s]) begin
                    bus.out_col_o[j] = rd_dat[s];
                end
            end
        end
    end

    assign bus.out_vld_o = out_vld_q;
    assign bus.out_sof_o = sof_q;
    assign bus.out_eol_o = eol_q;
    assign bus.primed_o  = (cnt_q == CNT_W'(N));
    assign bus.err_len_o = err_q;
endmodule

// File: tb/tb_conv_cntrl_lb_ring.sv
// Directed and random stream checks of conv_cntrl_lb_ring against a line-history reference model.
module tb_conv_cntrl_lb_ring;
    import conv_pkg::*;

    localparam int K = 5;
    localparam int W = 8;

    typedef logic [W-1:0][7:0] line_t;
    typedef struct packed {
        logic [K-1:0][7:0] col;
        logic              sof;
        logic              eol;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n;

    conv_cntrl_lb_ring_if #(.K(K)) bus ();

    conv_cntrl_lb_ring #(
        .K     (K),
        .W_MAX (W)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int    errors = 0;
    int    checks = 0;
    exp_t  expq[$];
    line_t hist[$];
    line_t cur;
    int    mcol = 0;
    bit    m_err = 1'b0;
    bit    m_primed = 1'b0;
    bit    rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit pick_rdy();
        return rnd_rdy ? ($urandom_range(0, 9) < 7) : 1'b1;
    endfunction

    // Reference: keep the last K-1 completed lines since SOF; row j of a column is line j back at this position.
    task automatic model_xfer(input pixel_t dat, input bit sof, input bit eol);
        exp_t e;
        if (sof) begin
            hist.delete();
            mcol  = 0;
            m_err = 1'b0;
        end
        e.col    = '0;
        e.col[0] = dat;
        for (int j = 1; j < K; j++) begin
            if (j <= hist.size()) e.col[j] = hist[hist.size() - j][mcol];
        end
        cur[mcol] = dat;
        e.sof = sof;
        e.eol = eol || (mcol == W - 1);
        if (mcol == W - 1 && !eol) m_err = 1'b1;
        expq.push_back(e);
        if (e.eol) begin
            hist.push_back(cur);
            if (hist.size() > K - 1) void'(hist.pop_front());
            mcol = 0;
        end else begin
            mcol++;
        end
        m_primed = (hist.size() == K - 1);
    endtask

    task automatic cyc(input bit vld, input pixel_t dat, input bit sof, input bit eol,
                       input bit rdy, output bit x);
        bit pop;
        bus.in_vld_i  = vld;
        bus.in_dat_i  = dat;
        bus.in_sof_i  = sof;
        bus.in_eol_i  = eol;
        bus.out_rdy_i = rdy;
        #1;
        chk("out_vld", 64'(bus.out_vld_o), 64'(expq.size() != 0));
        if (bus.out_vld_o && expq.size() != 0) begin
            chk("out_col", 64'(bus.out_col_o), 64'(expq[0].col));
            chk("out_sof", 64'(bus.out_sof_o), 64'(expq[0].sof));
            chk("out_eol", 64'(bus.out_eol_o), 64'(expq[0].eol));
        end
        chk("primed", 64'(bus.primed_o), 64'(m_primed));
        chk("err_len", 64'(bus.err_len_o), 64'(m_err));
        chk("in_rdy", 64'(bus.in_rdy_o), 64'(expq.size() == 0 || rdy));
        x   = vld && bus.in_rdy_o;
        pop = (expq.size() != 0) && rdy;
        @(posedge clk);
        if (pop) void'(expq.pop_front());
        if (x) model_xfer(dat, sof, eol);
        @(negedge clk);
    endtask

    task automatic send_pix(input pixel_t dat, input bit sof, input bit eol);
        bit x = 1'b0;
        for (int t = 0; t < 40 && !x; t++) cyc(1'b1, dat, sof, eol, pick_rdy(), x);
        if (!x) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic send_line(input int row, input bit sof);
        for (int c = 0; c < W; c++) send_pix(8'(row * 16 + c), sof && c == 0, c == W - 1);
    endtask

    task automatic idle(input int n);
        bit x;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, x);
    endtask

    task automatic do_reset();
        arst_n        = 1'b0;
        bus.in_vld_i  = 1'b0;
        bus.out_rdy_i = 1'b1;
        @(posedge clk);
        expq.delete();
        hist.delete();
        mcol     = 0;
        m_err    = 1'b0;
        m_primed = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit x;
        arst_n        = 1'b0;
        bus.in_vld_i  = 1'b0;
        bus.in_dat_i  = '0;
        bus.in_sof_i  = 1'b0;
        bus.in_eol_i  = 1'b0;
        bus.out_rdy_i = 1'b1;
        @(negedge clk);
        do_reset();
        idle(2);

        // Fill a frame: line 4 must see lines 3..0 above it, primed after the 4th EOL.
        for (int r = 0; r < 5; r++) send_line(r, r == 0);
        idle(2);
        chk("primed_after_frame", 64'(bus.primed_o), 64'(1));

        // New frame: upper rows padded, primed falls.
        send_line(0, 1'b1);
        chk("primed_new_frame", 64'(bus.primed_o), 64'(0));

        // Downstream stall for 3 cycles mid-line.
        for (int c = 0; c < 4; c++) send_pix(8'(16 + c), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h14, 1'b0, 1'b0, 1'b0, x);
        for (int c = 4; c < W; c++) send_pix(8'(16 + c), 1'b0, c == W - 1);

        // Overlong line: implicit EOL at column 7, remaining pixels start the next line.
        for (int c = 0; c < 10; c++) send_pix(8'(32 + c), 1'b0, 1'b0);
        chk("err_len_set", 64'(bus.err_len_o), 64'(1));
        for (int c = 2; c < W; c++) send_pix(8'(48 + c), 1'b0, c == W - 1);
        idle(1);

        // Reset at column 3 of line 2, then a SOF line.
        send_line(0, 1'b1);
        send_line(1, 1'b0);
        for (int c = 0; c < 3; c++) send_pix(8'(32 + c), 1'b0, 1'b0);
        do_reset();
        chk("reset_out_vld", 64'(bus.out_vld_o), 64'(0));
        chk("reset_primed", 64'(bus.primed_o), 64'(0));
        send_line(7, 1'b1);
        idle(1);

        // Ten continuous lines: the write selector wraps through all stores.
        for (int r = 0; r < 10; r++) send_line(r, r == 0);
        idle(2);
        chk("primed_after_ten", 64'(bus.primed_o), 64'(1));

        // Random data, gaps, stalls, occasional SOF and implicit EOLs.
        rnd_rdy = 1'b1;
        for (int l = 0; l < 40; l++) begin
            bit sof_l = ($urandom_range(0, 7) == 0);
            bit eol_l = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < W; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    for (int g = 0; g < int'($urandom_range(1, 2)); g++)
                        cyc(1'b0, '0, 1'b0, 1'b0, pick_rdy(), x);
                end
                send_pix(8'($urandom), sof_l && c == 0, eol_l && c == W - 1);
            end
        end
        rnd_rdy = 1'b0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
